// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM-style fetch front end.
package arm_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A00000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO between instruction memory and ID; flush beats push and pop.
module fetch_queue
  import arm_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop only a valid head; push into a full queue only when it is draining.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != DEPTH_C) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; validity is carried by count.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, redirect handling and prefetch buffering in front of the ID stage.
// Optional FETCH_PERF_EN adds saturating fetch/flush/stall counters.
module instruction_fetch_unit
  import arm_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed,
  output logic [31:0]        perf_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  last_pc;
  logic [INSTR_W-1:0] last_instr;
  fetch_entry_t       q_head;
  fetch_entry_t       q_wdata;
  logic [PTR_W:0]     q_count;
  logic               q_empty;
  logic               q_full;
  logic               q_push;
  logic               q_pop;

  // A redirect suppresses both the push of this cycle's word and any pop.
  always_comb begin
    q_empty = (q_count == '0);
    q_full  = (q_count == DEPTH_C);
    q_pop   = !q_empty && id_ready && !branch_taken;
    q_push  = !branch_taken && (!q_full || q_pop);
    q_wdata = '{pc: fetch_pc + 32'd4, instr: imem_instr};
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst)               fetch_pc <= RESET_PC;
    else if (branch_taken) fetch_pc <= align_word(branch_addr);
    else if (q_push)       fetch_pc <= fetch_pc + 32'd4;
  end

  // Remembers what ID last saw so the outputs hold while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc    <= '0;
      last_instr <= '0;
    end else begin
      last_pc    <= id_pc;
      last_instr <= id_instr;
    end
  end

  assign imem_pc  = fetch_pc;
  assign id_valid = !q_empty;
  assign id_pc    = q_empty ? last_pc    : q_head.pc;
  assign id_instr = q_empty ? last_instr : q_head.instr;

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [31:0] flush_amt;
  assign flush_amt = {{(31-PTR_W){1'b0}}, q_count} + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (q_push)               perf_fetched <= sat_add(perf_fetched, 32'd1);
      if (branch_taken)         perf_flushed <= sat_add(perf_flushed, flush_amt);
      if (q_full && !id_ready)  perf_stall   <= sat_add(perf_stall, 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized run against a queue model.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        id_ready = 1'b0;
  logic [31:0] imem_pc, imem_instr, id_pc, id_instr;
  logic        id_valid;

  logic        rst2 = 1'b1;
  logic        branch_taken2 = 1'b0;
  logic [31:0] branch_addr2 = '0;
  logic        id_ready2 = 1'b1;
  logic [31:0] imem_pc2, imem_instr2, id_pc2, id_instr2;
  logic        id_valid2;

  int checks = 0;
  int passes = 0;

  logic [31:0] m_pc;
  ent_t        m_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hE1A0_0000;
  endfunction

  assign imem_instr  = rom(imem_pc);
  assign imem_instr2 = rom(imem_pc2);

  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .id_ready(id_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr)
  );

  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .imem_pc(imem_pc2), .imem_instr(imem_instr2),
    .branch_taken(branch_taken2), .branch_addr(branch_addr2), .id_ready(id_ready2),
    .id_valid(id_valid2), .id_pc(id_pc2), .id_instr(id_instr2)
  );

  // Reference: a bounded queue of {pc+4, word} fed from a word-stepping fetch address.
  task automatic model_step(input logic r, input logic b, input logic [31:0] a, input logic rdy);
    bit popped;
    if (r) begin
      m_pc = 32'h0;
      m_q.delete();
    end else if (b) begin
      m_q.delete();
      m_pc = a & ~32'h3;
    end else begin
      popped = (m_q.size() > 0) && rdy;
      if (popped) void'(m_q.pop_front());
      if (m_q.size() < DEPTH) begin
        m_q.push_back('{pc: m_pc + 32'd4, instr: rom(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic b, input logic [31:0] a, input logic rdy);
    rst = r; branch_taken = b; branch_addr = a; id_ready = rdy;
    @(posedge clk);
    model_step(r, b, a, rdy);
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    checks++; if (id_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", id_valid); else passes++;
    checks++; if (id_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", id_pc); else passes++;
    checks++; if (id_instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", id_instr); else passes++;
    checks++; if (imem_pc !== 32'h0) $display("FAIL reset_imem_pc got=%h exp=0", imem_pc); else passes++;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1);
      checks++; if (id_valid !== 1'b1) $display("FAIL run_valid[%0d] got=%b exp=1", i, id_valid); else passes++;
      checks++; if (id_pc !== 32'(4 * (i + 1))) $display("FAIL run_pc[%0d] got=%h exp=%h", i, id_pc, 32'(4 * (i + 1))); else passes++;
      checks++; if (id_instr !== rom(32'(4 * i))) $display("FAIL run_instr[%0d] got=%h exp=%h", i, id_instr, rom(32'(4 * i))); else passes++;
    end
  endtask

  task automatic test_fill;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    checks++; if (imem_pc !== 32'h8) $display("FAIL fill_imem_pc got=%h exp=8", imem_pc); else passes++;
    checks++; if (id_pc !== 32'h4 || id_instr !== rom(0)) $display("FAIL fill_head got=%h/%h exp=4/%h", id_pc, id_instr, rom(0)); else passes++;
    for (int i = 1; i <= 2; i++) begin
      cycle(0, 0, 0, 1);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 + 4 * i) || id_instr !== rom(32'(4 * i)))
        $display("FAIL drain[%0d] got=%b/%h/%h exp=1/%h/%h", i, id_valid, id_pc, id_instr, 32'(4 + 4 * i), rom(32'(4 * i)));
      else passes++;
    end
  endtask

  task automatic test_redirect;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h94, 0);
    checks++; if (id_valid !== 1'b0) $display("FAIL redir_valid got=%b exp=0", id_valid); else passes++;
    checks++; if (imem_pc !== 32'h94) $display("FAIL redir_imem_pc got=%h exp=94", imem_pc); else passes++;
    cycle(0, 0, 0, 0);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h98 || id_instr !== rom(32'h94))
      $display("FAIL redir_target got=%b/%h/%h exp=1/98/%h", id_valid, id_pc, id_instr, rom(32'h94));
    else passes++;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h200, 1);
    checks++; if (id_valid !== 1'b0) $display("FAIL redir_pop_valid got=%b exp=0", id_valid); else passes++;
    cycle(0, 0, 0, 1);
    checks++; if (id_pc !== 32'h204) $display("FAIL redir_pop_pc got=%h exp=204", id_pc); else passes++;
  endtask

  task automatic test_back_to_back;
    cycle(0, 1, 32'h40, 1);
    cycle(0, 1, 32'h80, 1);
    checks++; if (id_valid !== 1'b0 || imem_pc !== 32'h80) $display("FAIL b2b_flush got=%b/%h exp=0/80", id_valid, imem_pc); else passes++;
    cycle(0, 0, 0, 1);
    checks++; if (id_pc !== 32'h84 || id_instr !== rom(32'h80)) $display("FAIL b2b_first got=%h/%h exp=84/%h", id_pc, id_instr, rom(32'h80)); else passes++;
    cycle(0, 0, 0, 1);
    checks++; if (id_pc !== 32'h88) $display("FAIL b2b_second got=%h exp=88", id_pc); else passes++;
  endtask

  task automatic test_align;
    cycle(0, 1, 32'h103, 1);
    checks++; if (imem_pc !== 32'h100) $display("FAIL align_imem_pc got=%h exp=100", imem_pc); else passes++;
    cycle(0, 0, 0, 1);
    checks++; if (id_pc !== 32'h104 || id_instr !== rom(32'h100)) $display("FAIL align_head got=%h/%h exp=104/%h", id_pc, id_instr, rom(32'h100)); else passes++;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    cycle(1, 1, 32'h500, 1);
    checks++; if (id_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", id_valid); else passes++;
    checks++; if (imem_pc !== 32'h0) $display("FAIL rstmid_imem_pc got=%h exp=0", imem_pc); else passes++;
  endtask

  task automatic test_wrap;
    logic [31:0] exp_fetch [3];
    exp_fetch[0] = 32'hFFFF_FFFC; exp_fetch[1] = 32'h0; exp_fetch[2] = 32'h4;
    rst2 = 1'b1;
    cycle(0, 0, 0, 1);
    checks++; if (imem_pc2 !== 32'hFFFF_FFF8) $display("FAIL wrap_reset_pc got=%h exp=fffffff8", imem_pc2); else passes++;
    rst2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1);
      checks++;
      if (id_valid2 !== 1'b1 || id_pc2 !== exp_fetch[i] || id_instr2 !== rom(exp_fetch[i] - 32'd4))
        $display("FAIL wrap[%0d] got=%b/%h/%h exp=1/%h/%h", i, id_valid2, id_pc2, id_instr2, exp_fetch[i], rom(exp_fetch[i] - 32'd4));
      else passes++;
    end
  endtask

  task automatic test_random;
    logic r, b, rdy;
    logic [31:0] a;
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(63) == 0);
      b   = ($urandom_range(7) == 0);
      rdy = ($urandom_range(2) != 0);
      a   = {20'h0, 12'($urandom)};
      cycle(r, b, a, rdy);
      checks++; if (imem_pc !== m_pc) $display("FAIL rnd_imem_pc[%0d] got=%h exp=%h", i, imem_pc, m_pc); else passes++;
      checks++; if (id_valid !== (m_q.size() != 0)) $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, id_valid, m_q.size() != 0); else passes++;
      if (m_q.size() != 0) begin
        checks++;
        if (id_pc !== m_q[0].pc || id_instr !== m_q[0].instr)
          $display("FAIL rnd_head[%0d] got=%h/%h exp=%h/%h", i, id_pc, id_instr, m_q[0].pc, m_q[0].instr);
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_redirect();
    test_back_to_back();
    test_align();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
